rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter with a registered, strictly one-hot grant. Sits directly upstream of the 8-to-3 encoder and drives that encoder's 8-bit input.
- Guarantees the grant vector is either all-zero or exactly one-hot. Consumers qualify it with gnt_valid, because an all-zero input to the encoder gives an undefined index.
- Adds fairness, grant holding, and a hold-time limit.

Parameters:
- HOLD_MAX, 16, maximum cycles one grant may be held before it is forcibly released. Range 1..31; 0 disables the limit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  8  request vector; bit k is requester k. Any number of bits may be set.
- rel  input  1  release pulse from the current grantee; ends the grant.
- gnt  output  8  registered grant; all-zero or exactly one-hot.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- busy  output  1  high while in GRANT state; equals gnt_valid.

Behaviour:
Interface:
- One clock, clk. Reset rst_n is synchronous and active-low.
- All outputs are registered. No combinational path exists from any input to any output.

Reset:
- gnt=8'h00, gnt_valid=0, busy=0.
- State=IDLE, priority pointer ptr=3'd0, hold counter hcnt=0.
- Reset asserted mid-grant: gnt drops to 0 on that edge, and ptr returns to 0 (not advanced).

States:
- IDLE: gnt=0.
  - If req!=0 at edge k, select the first set bit, searching cyclically from index ptr upward: ptr, ptr+1, ... ptr+7, modulo 8.
  - The winner w is latched, gnt=1<<w appears after edge k (latency 1 cycle), hcnt=1, go to GRANT.
  - If req==0, stay in IDLE. rel is ignored in IDLE.
- GRANT: the grant is terminated at an edge if any of the following holds:
  (a) rel=1;
  (b) req[w]=0;
  (c) HOLD_MAX!=0 and hcnt==HOLD_MAX.
- On termination: gnt=0, gnt_valid=0, ptr=(w+1) mod 8, hcnt=0, go to IDLE.
- Otherwise: gnt unchanged and hcnt increments. hcnt saturates at 31.
- Bits of req other than w are ignored during GRANT.

Timing and fairness rules:
- Exactly one idle (all-zero) cycle separates consecutive grants. Back-to-back grants never occur, so the downstream encoder always sees a clean 0 -> one-hot transition.
- Grant length with no rel and req held is exactly HOLD_MAX cycles.
- Fairness: with all 8 requesting continuously, each requester is granted once per 8 grants, in ascending cyclic order.

Boundary and simultaneous events:
- Pointer wrap: w=7 gives ptr=0.
- Simultaneous terminating conditions (rel together with req drop or timeout) count as a single termination.
- rel and new requests at the same edge: termination takes priority. The new arbitration happens in the following IDLE cycle.
- The winner is chosen from req sampled at the IDLE edge only. req pulses shorter than one cycle that occur during GRANT are lost; requesters must hold req until granted.

Invariants:
- $onehot0(gnt) at every edge.
- gnt_valid == |gnt.

Test Plan:
1. Reset, then req=8'hFF held, rel pulsed on the 2nd cycle of each grant -> gnt sequence 01,00,02,00,04,00,08,00,10,00,20,00,40,00,80,00,01; gnt_valid tracks gnt!=0.
2. Reset, req=8'b0010_0100 -> gnt=8'h04 one cycle later. Pulse rel -> 00, then gnt=8'h20 (ptr=3 skips bit 2). Pulse rel again -> 00, then gnt=8'h04 (wrap-around).
3. HOLD_MAX=16, req=8'h01 held, rel=0 -> gnt=8'h01 for exactly 16 cycles, 8'h00 for 1 cycle, then 8'h01 again.
4. While gnt=8'h08, deassert req[3] with req[5] high -> gnt=00 on the next edge, then gnt=8'h20 the cycle after.
5. While gnt=8'h40, drive rst_n=0 for one edge -> gnt=00 and gnt_valid=0 on that edge. Release reset with req=8'hC1 -> gnt=8'h01 (ptr reset to 0).
6. rel=1 in IDLE with req=0 -> no state change. rel=1 together with req[w]=0 in GRANT -> single termination, ptr advanced by exactly one position past w.

Source files
------------

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with a registered one-hot grant, grant holding
// and a configurable hold-time limit. Exactly one idle cycle separates grants.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       busy
);

  localparam int unsigned CNT_W   = 5;
  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_SAT = 5'd31;

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       win_q, win_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             busy_q, busy_d;

  logic [2:0] pick_idx;
  logic       pick_found;
  logic       hold_hit;
  logic       term;

  // First set request searching cyclically upward from ptr; lowest offset wins.
  always_comb begin
    pick_idx   = 3'd0;
    pick_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr_q + 3'(i)]) begin
        pick_idx   = ptr_q + 3'(i);
        pick_found = 1'b1;
      end
    end
  end

  assign hold_hit = (HOLD_MAX != 0) && (hcnt_q == CNT_W'(HOLD_MAX));
  assign term     = rel || !req[win_q] || hold_hit;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    hcnt_d      = hcnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_GRANT;
          win_d       = pick_idx;
          hcnt_d      = 5'd1;
          gnt_d       = 8'h01 << pick_idx;
          gnt_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_GRANT: begin
        if (term) begin
          state_d     = S_IDLE;
          ptr_d       = win_q + 3'd1;
          hcnt_d      = '0;
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (hcnt_q != CNT_SAT) begin
          hcnt_d = hcnt_q + 5'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      win_q       <= 3'd0;
      hcnt_q      <= '0;
      gnt_q       <= 8'h00;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      hcnt_q      <= hcnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: directed scenarios plus randomized traffic,
// checked against a requester-level round-robin model.
module tb_rr_arbiter8;

  localparam int HM = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       busy;

  rr_arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  // Reference model: who holds the grant, where the search starts, how long held.
  int owner = -1;
  int ptr   = 0;
  int held  = 0;

  function automatic void model_step(input logic r_n, input logic [7:0] rq, input logic rl);
    if (!r_n) begin
      owner = -1; ptr = 0; held = 0;
    end else if (owner < 0) begin
      for (int i = 0; i < 8; i++) begin
        if (owner < 0 && rq[(ptr + i) % 8]) begin
          owner = (ptr + i) % 8;
          held  = 1;
        end
      end
    end else if (rl || !rq[owner] || (HM != 0 && held == HM)) begin
      ptr   = (owner + 1) % 8;
      owner = -1;
      held  = 0;
    end else if (held < 31) begin
      held++;
    end
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic r_n, input logic [7:0] rq, input logic rl);
    logic [7:0] e;
    @(negedge clk);
    rst_n = r_n; req = rq; rel = rl;
    model_step(r_n, rq, rl);
    e = (owner < 0) ? 8'h00 : (8'h01 << owner);
    exp_q.push_back(e);
  endtask

  // Monitor: every edge with a pending expectation is compared.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== e) begin
          n_bad++;
          $display("FAIL gnt: got %02h want %02h at %0t", gnt, e, $time);
        end
        n_cmp++;
        if (gnt_valid !== (e != 8'h00)) begin
          n_bad++;
          $display("FAIL gnt_valid: got %b want %b at %0t", gnt_valid, (e != 8'h00), $time);
        end
        n_cmp++;
        if (busy !== (e != 8'h00)) begin
          n_bad++;
          $display("FAIL busy: got %b want %b at %0t", busy, (e != 8'h00), $time);
        end
        n_cmp++;
        if (!$onehot0(gnt)) begin
          n_bad++;
          $display("FAIL onehot0: got %02h want zero-or-onehot at %0t", gnt, $time);
        end
      end
    end
  end

  initial begin
    logic [7:0] rq;
    logic       rl;
    int         hold_left;
    int         guard;
    rst_n = 1'b0; req = 8'h00; rel = 1'b0;

    // Reset state
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    // All requesting, rel on 2nd grant cycle: full ascending rotation plus wrap
    for (int g = 0; g < 9; g++) begin
      cyc(1'b1, 8'hFF, 1'b0);
      cyc(1'b1, 8'hFF, 1'b1);
    end

    // Skip-ahead and wrap-around with two requesters
    cyc(1'b0, 8'h00, 1'b0);
    for (int g = 0; g < 3; g++) begin
      cyc(1'b1, 8'h24, 1'b0);
      cyc(1'b1, 8'h24, 1'b0);
      cyc(1'b1, 8'h24, 1'b1);
    end

    // Hold limit with a single steady requester
    cyc(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 2 * HM + 4; c++) cyc(1'b1, 8'h01, 1'b0);

    // Grantee drops request, next requester follows after one idle cycle
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h08, 1'b0);
    cyc(1'b1, 8'h28, 1'b0);
    cyc(1'b1, 8'h20, 1'b0);
    cyc(1'b1, 8'h20, 1'b0);
    cyc(1'b1, 8'h20, 1'b1);

    // Reset mid-grant, then pointer restarts at 0
    cyc(1'b1, 8'h40, 1'b0);
    cyc(1'b1, 8'h40, 1'b0);
    cyc(1'b0, 8'hC1, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0);
    cyc(1'b1, 8'hC1, 1'b1);

    // rel in idle with no requests; rel with req drop as one termination
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h10, 1'b0);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1);

    // Randomized traffic with held request patterns and occasional reset
    rq = 8'h00;
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        rq = 8'($urandom);
        if ($urandom_range(0, 3) == 0) rq = 8'h01 << $urandom_range(0, 7);
        hold_left = $urandom_range(1, 24);
      end
      hold_left--;
      rl = ($urandom_range(0, 5) == 0);
      cyc(($urandom_range(0, 99) != 0), rq, rl);
    end
    cyc(1'b1, 8'h00, 1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
